// File: rtl/control_sequencer.sv
// FPG8 fetch/decode/execute sequencer: one DATA driver per cycle, memory stalls via mem_ready, sticky timeout.
// ILLEGAL_TRAP_EN: opcodes 9-E halt and set sticky illegal_op; otherwise they retire as NOP.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       s_bit,
    input  logic [1:0] shift,
    input  logic [2:0] rd_1,
    input  logic [2:0] rs_1,
    input  logic [2:0] rs_2,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       ir_in,
    output logic       pc_out,
    output logic       pc_in,
    output logic       pc_inc,
    output logic       mar_in,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [2:0] reg_sel,
    output logic       reg_out,
    output logic       reg_in,
    output logic       a_in,
    output logic       z_in,
    output logic       z_out,
    output logic       flags_in,
    output logic [1:0] alu_op,
    output logic [1:0] alu_shift,
    output logic       halted,
    output logic       bus_err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_DEC, S_E0, S_E1, S_E2, S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;

    logic is_alu, is_ld, is_st, is_br, is_bz, is_hlt;
    logic in_wait, timeout_hit;

    assign is_alu = (opcode >= 4'd1) && (opcode <= 4'd4);
    assign is_ld  = (opcode == 4'd5);
    assign is_st  = (opcode == 4'd6);
    assign is_br  = (opcode == 4'd7);
    assign is_bz  = (opcode == 4'd8);
    assign is_hlt = (opcode == 4'hF);

`ifdef ILLEGAL_TRAP_EN
    logic is_ill;
    assign is_ill = (opcode >= 4'd9) && (opcode <= 4'hE);
`endif

    assign in_wait = (state == S_F1) || ((state == S_E1) && (is_ld || is_st));
    // A ready response in the limit cycle still completes normally.
    assign timeout_hit = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                         (wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_wait && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if (timeout_hit)
                bus_err <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)
            illegal_op <= 1'b0;
        else if (state == S_DEC && is_ill)
            illegal_op <= 1'b1;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_F0;
            S_F0:   state_nxt = S_F1;
            S_F1: begin
                if (mem_ready)        state_nxt = S_DEC;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_DEC: begin
                if (is_alu || is_ld || is_st || is_br) state_nxt = S_E0;
                else if (is_bz)                        state_nxt = zero_flag ? S_E0 : S_F0;
                else if (is_hlt)                       state_nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                else if (is_ill)                       state_nxt = S_HALT;
`endif
                else                                   state_nxt = S_F0;
            end
            S_E0:   state_nxt = (is_alu || is_ld || is_st) ? S_E1 : S_F0;
            S_E1: begin
                if (is_alu)           state_nxt = S_E2;
                else if (mem_ready)   state_nxt = S_F0;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_E2:   state_nxt = S_F0;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ir_in     = 1'b0;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        pc_inc    = 1'b0;
        mar_in    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        reg_sel   = 3'd0;
        reg_out   = 1'b0;
        reg_in    = 1'b0;
        a_in      = 1'b0;
        z_in      = 1'b0;
        z_out     = 1'b0;
        flags_in  = 1'b0;
        alu_op    = 2'd0;
        alu_shift = 2'd0;
        halted    = 1'b0;
        case (state)
            S_F0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end
            S_F1: begin
                mem_rd = 1'b1;
                ir_in  = mem_ready;
                pc_inc = mem_ready;
            end
            S_E0: begin
                reg_sel = rs_1;
                reg_out = 1'b1;
                a_in    = is_alu;
                mar_in  = is_ld || is_st;
                pc_in   = is_br || is_bz;
            end
            S_E1: begin
                if (is_alu) begin
                    reg_sel   = rs_2;
                    reg_out   = 1'b1;
                    z_in      = 1'b1;
                    alu_op    = opcode[1:0] - 2'd1;
                    alu_shift = shift;
                end else if (is_ld) begin
                    reg_sel = rd_1;
                    mem_rd  = 1'b1;
                    reg_in  = mem_ready;
                end else if (is_st) begin
                    reg_sel = rd_1;
                    reg_out = 1'b1;
                    mem_wr  = 1'b1;
                end
            end
            S_E2: begin
                z_out    = 1'b1;
                reg_sel  = rd_1;
                reg_in   = 1'b1;
                flags_in = s_bit;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: random instruction stream checked cycle by cycle against a per-instruction strobe model.
module tb_control_sequencer;

    localparam int T = 4;

    typedef struct packed {
        logic       ir_in, pc_out, pc_in, pc_inc, mar_in, mem_rd, mem_wr;
        logic [2:0] reg_sel;
        logic       reg_out, reg_in, a_in, z_in, z_out, flags_in;
        logic [1:0] alu_op, alu_shift;
        logic       halted, bus_err;
    } sig_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, t_reset, mem_ready, t_mem_ready, s_bit, zero_flag;
    logic [3:0] opcode;
    logic [1:0] shift;
    logic [2:0] rd_1, rs_1, rs_2;

    logic       ir_in, pc_out, pc_in, pc_inc, mar_in, mem_rd, mem_wr, reg_out, reg_in;
    logic       a_in, z_in, z_out, flags_in, halted, bus_err, illegal_op;
    logic [2:0] reg_sel;
    logic [1:0] alu_op, alu_shift;
    logic       t_ir_in, t_pc_out, t_pc_in, t_pc_inc, t_mar_in, t_mem_rd, t_mem_wr, t_reg_out, t_reg_in;
    logic       t_a_in, t_z_in, t_z_out, t_flags_in, t_halted, t_bus_err, t_illegal_op;
    logic [2:0] t_reg_sel;
    logic [1:0] t_alu_op, t_alu_shift;

    sig_t obs, t_obs;
    assign obs = {ir_in, pc_out, pc_in, pc_inc, mar_in, mem_rd, mem_wr, reg_sel, reg_out, reg_in,
                  a_in, z_in, z_out, flags_in, alu_op, alu_shift, halted, bus_err};
    assign t_obs = {t_ir_in, t_pc_out, t_pc_in, t_pc_inc, t_mar_in, t_mem_rd, t_mem_wr, t_reg_sel,
                    t_reg_out, t_reg_in, t_a_in, t_z_in, t_z_out, t_flags_in, t_alu_op, t_alu_shift,
                    t_halted, t_bus_err};

`ifndef ILLEGAL_TRAP_EN
    assign illegal_op   = 1'b0;
    assign t_illegal_op = 1'b0;
`endif

    control_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .s_bit(s_bit), .shift(shift),
        .rd_1(rd_1), .rs_1(rs_1), .rs_2(rs_2), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .ir_in(ir_in), .pc_out(pc_out), .pc_in(pc_in), .pc_inc(pc_inc), .mar_in(mar_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_sel(reg_sel), .reg_out(reg_out), .reg_in(reg_in),
        .a_in(a_in), .z_in(z_in), .z_out(z_out), .flags_in(flags_in), .alu_op(alu_op),
        .alu_shift(alu_shift), .halted(halted), .bus_err(bus_err)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    control_sequencer #(.MEM_TIMEOUT(T), .CNT_W(4)) dut_t (
        .clk(clk), .reset(t_reset), .opcode(opcode), .s_bit(s_bit), .shift(shift),
        .rd_1(rd_1), .rs_1(rs_1), .rs_2(rs_2), .zero_flag(zero_flag), .mem_ready(t_mem_ready),
        .ir_in(t_ir_in), .pc_out(t_pc_out), .pc_in(t_pc_in), .pc_inc(t_pc_inc), .mar_in(t_mar_in),
        .mem_rd(t_mem_rd), .mem_wr(t_mem_wr), .reg_sel(t_reg_sel), .reg_out(t_reg_out),
        .reg_in(t_reg_in), .a_in(t_a_in), .z_in(t_z_in), .z_out(t_z_out), .flags_in(t_flags_in),
        .alu_op(t_alu_op), .alu_shift(t_alu_shift), .halted(t_halted), .bus_err(t_bus_err)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_op(t_illegal_op)
`endif
    );

    int checks = 0;
    int errors = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int n_drv(input sig_t s);
        return int'(s.pc_out) + int'(s.reg_out) + int'(s.z_out) + int'(s.mem_rd);
    endfunction

    task automatic chk(input string tag, input sig_t got, input sig_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        checks++;
        assert (n_drv(got) <= 1) else begin
            errors++;
            $error("FAIL %s_bus observed=%0d drivers expected<=1", tag, n_drv(got));
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One cycle: drive mem_ready, sample mid-cycle, advance to just after the next edge.
    task automatic cyc(input bit t, input logic rdy, input sig_t exp, input string tag);
        if (t) t_mem_ready = rdy; else mem_ready = rdy;
        #2;
        chk(tag, t ? t_obs : obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [3:0] op, input logic s, input logic [1:0] sh,
                          input logic [2:0] rd, input logic [2:0] r1, input logic [2:0] r2,
                          input logic z);
        opcode = op; s_bit = s; shift = sh; rd_1 = rd; rs_1 = r1; rs_2 = r2; zero_flag = z;
    endtask

    task automatic fetch(input bit t, input int nw);
        sig_t e;
        e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1;
        cyc(t, rbit(), e, "F0");
        for (int i = 0; i < nw; i++) begin
            e = '0; e.mem_rd = 1'b1;
            cyc(t, 1'b0, e, "F1_wait");
        end
        e = '0; e.mem_rd = 1'b1; e.ir_in = 1'b1; e.pc_inc = 1'b1;
        cyc(t, 1'b1, e, "F1_done");
        cyc(t, rbit(), '0, "DEC");
    endtask

    // Execute-phase strobes of the instruction currently on the IR inputs.
    task automatic execute(input bit t, input int nw);
        sig_t e;
        case (opcode)
            4'd1, 4'd2, 4'd3, 4'd4: begin
                e = '0; e.reg_sel = rs_1; e.reg_out = 1'b1; e.a_in = 1'b1;
                cyc(t, rbit(), e, "ALU_E0");
                e = '0; e.reg_sel = rs_2; e.reg_out = 1'b1; e.z_in = 1'b1;
                e.alu_op = 2'(opcode - 4'd1); e.alu_shift = shift;
                cyc(t, rbit(), e, "ALU_E1");
                e = '0; e.z_out = 1'b1; e.reg_sel = rd_1; e.reg_in = 1'b1; e.flags_in = s_bit;
                cyc(t, rbit(), e, "ALU_E2");
            end
            4'd5, 4'd6: begin
                e = '0; e.reg_sel = rs_1; e.reg_out = 1'b1; e.mar_in = 1'b1;
                cyc(t, rbit(), e, "MEM_E0");
                e = '0; e.reg_sel = rd_1;
                if (opcode == 4'd5) e.mem_rd = 1'b1;
                else begin e.reg_out = 1'b1; e.mem_wr = 1'b1; end
                for (int i = 0; i < nw; i++) cyc(t, 1'b0, e, "MEM_E1_wait");
                e.reg_in = (opcode == 4'd5);
                cyc(t, 1'b1, e, "MEM_E1_done");
            end
            4'd7: begin
                e = '0; e.reg_sel = rs_1; e.reg_out = 1'b1; e.pc_in = 1'b1;
                cyc(t, rbit(), e, "BR_E0");
            end
            4'd8: begin
                if (zero_flag) begin
                    e = '0; e.reg_sel = rs_1; e.reg_out = 1'b1; e.pc_in = 1'b1;
                    cyc(t, rbit(), e, "BZ_E0");
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1, '0, "IDLE");
    endtask

    initial begin
        sig_t e;
        t_reset = 1'b1;
        t_mem_ready = 1'b1;
        set_ir(4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);

        do_reset();
        chk_bit("illegal_rst", illegal_op, 1'b0);

        set_ir(4'd1, 1'b1, 2'b01, 3'd3, 3'd1, 3'd2, 1'b0);
        fetch(1'b0, 0); execute(1'b0, 0);

        set_ir(4'd5, 1'b0, 2'd0, 3'd4, 3'd6, 3'd0, 1'b0);
        fetch(1'b0, 1); execute(1'b0, 5);

        set_ir(4'd8, 1'b0, 2'd0, 3'd0, 3'd5, 3'd0, 1'b0);
        fetch(1'b0, 0); execute(1'b0, 0);
        set_ir(4'd8, 1'b0, 2'd0, 3'd0, 3'd5, 3'd0, 1'b1);
        fetch(1'b0, 0); execute(1'b0, 0);

        for (int n = 0; n < 80; n++) begin
`ifdef ILLEGAL_TRAP_EN
            set_ir(4'($urandom_range(0, 8)), rbit(), 2'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), rbit());
`else
            set_ir(4'($urandom_range(0, 14)), rbit(), 2'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), rbit());
`endif
            fetch(1'b0, $urandom_range(0, 3));
            execute(1'b0, $urandom_range(0, 4));
        end

        // Reset while LD is stalled in E1.
        set_ir(4'd5, 1'b0, 2'd0, 3'd2, 3'd1, 3'd0, 1'b0);
        fetch(1'b0, 0);
        e = '0; e.reg_sel = 3'd1; e.reg_out = 1'b1; e.mar_in = 1'b1;
        cyc(1'b0, 1'b1, e, "RST_E0");
        e = '0; e.reg_sel = 3'd2; e.mem_rd = 1'b1;
        reset = 1'b1;
        cyc(1'b0, 1'b0, e, "RST_E1");
        reset = 1'b0;
        cyc(1'b0, 1'b0, '0, "RST_after");

        set_ir(4'hA, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        fetch(1'b0, 0);
`ifdef ILLEGAL_TRAP_EN
        e = '0; e.halted = 1'b1;
        cyc(1'b0, rbit(), e, "ILL_HALT");
        chk_bit("illegal_set", illegal_op, 1'b1);
        cyc(1'b0, rbit(), e, "ILL_HALT2");
        do_reset();
        chk_bit("illegal_clr", illegal_op, 1'b0);
`else
        execute(1'b0, 0);
        chk_bit("illegal_off", illegal_op, 1'b0);
`endif

        set_ir(4'hF, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        fetch(1'b0, 0);
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, rbit(), e, "HLT");
        do_reset();
        reset = 1'b1;

        // Short-timeout instance: ready on the limit cycle, then a stuck store.
        repeat (2) @(posedge clk);
        #1;
        t_reset = 1'b0;
        cyc(1'b1, 1'b1, '0, "T_IDLE");
        set_ir(4'd5, 1'b0, 2'd0, 3'd7, 3'd3, 3'd0, 1'b0);
        fetch(1'b1, T); execute(1'b1, T);
        set_ir(4'd6, 1'b0, 2'd0, 3'd5, 3'd4, 3'd0, 1'b0);
        fetch(1'b1, 0);
        e = '0; e.reg_sel = 3'd4; e.reg_out = 1'b1; e.mar_in = 1'b1;
        cyc(1'b1, 1'b1, e, "T_ST_E0");
        e = '0; e.reg_sel = 3'd5; e.reg_out = 1'b1; e.mem_wr = 1'b1;
        for (int i = 0; i <= T; i++) cyc(1'b1, 1'b0, e, "T_ST_wait");
        e = '0; e.halted = 1'b1; e.bus_err = 1'b1;
        cyc(1'b1, 1'b1, e, "T_TIMEOUT");
        cyc(1'b1, 1'b0, e, "T_TIMEOUT2");
        t_reset = 1'b1;
        @(posedge clk);
        #1;
        t_reset = 1'b0;
        cyc(1'b1, 1'b1, '0, "T_CLEAR");
        chk_bit("t_illegal", t_illegal_op, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
